// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv issue controller: FSM encoding,
// exception codes, register indices and the busy decode.
package multdiv_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_BLANK = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_WB    = 3'd4;
   localparam logic [2:0] ST_DRAIN = 3'd5;

   localparam logic [31:0] EXC_CODE_MUL = 32'd4;
   localparam logic [31:0] EXC_CODE_DIV = 32'd5;

   localparam logic [4:0] REG_ZERO    = 5'd0;
   localparam logic [4:0] REG_RSTATUS = 5'd30;

   localparam int WD_WIDTH = 7;

   // An op owns its destination register from the start pulse until writeback completes.
   function automatic logic is_busy(input logic [2:0] st);
      return (st == ST_START) || (st == ST_BLANK) || (st == ST_WAIT) || (st == ST_WB);
   endfunction

endpackage

// File: rtl/multdiv_watchdog.sv
// Cycle counter bounding how long the controller waits on multdiv.
// Clear has priority over enable; terminal is a decode of the current count.
module multdiv_watchdog
   import multdiv_pkg::*;
#(
   parameter int WIDTH    = WD_WIDTH,
   parameter int TERMINAL = 63
) (
   input  logic clock,
   input  logic ctrl_reset_n,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   localparam logic [WIDTH-1:0] TC = WIDTH'(TERMINAL);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign terminal = (cnt_q == TC);

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issues one MULT/DIV at a time to the shared multdiv unit, waits for its
// result under a watchdog, and presents it on a held writeback handshake.
module multdiv_issue_ctrl
   import multdiv_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 64,
   parameter logic [4:0]  EXC_REG        = REG_RSTATUS
) (
   input  logic        clock,
   input  logic        ctrl_reset_n,
   input  logic        issue_valid,
   input  logic        issue_is_div,
   input  logic [31:0] issue_a,
   input  logic [31:0] issue_b,
   input  logic [4:0]  issue_rd,
   output logic        issue_ready,
   input  logic        flush,
   input  logic [4:0]  src1_rd,
   input  logic [4:0]  src2_rd,
   output logic        hazard_stall,
   output logic [31:0] md_operandA,
   output logic [31:0] md_operandB,
   output logic        md_ctrl_MULT,
   output logic        md_ctrl_DIV,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   input  logic        md_resultRDY,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_exception,
   input  logic        wb_ready
);

   logic [2:0]  state_q, state_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [4:0]  rd_q, rd_d;
   logic        is_div_q, is_div_d;
   logic        drain_new_q, drain_new_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        wb_exc_q, wb_exc_d;
   logic        wd_clear, wd_enable, wd_tc;

   multdiv_watchdog #(
      .WIDTH    (WD_WIDTH),
      .TERMINAL (TIMEOUT_CYCLES - 1)
   ) u_watchdog (
      .clock        (clock),
      .ctrl_reset_n (ctrl_reset_n),
      .clear        (wd_clear),
      .enable       (wd_enable),
      .terminal     (wd_tc)
   );

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      rd_d        = rd_q;
      is_div_d    = is_div_q;
      drain_new_d = 1'b0;
      wb_rd_d     = wb_rd_q;
      wb_data_d   = wb_data_q;
      wb_exc_d    = wb_exc_q;
      wd_clear    = 1'b0;
      wd_enable   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (issue_valid && !flush) begin
               a_d      = issue_a;
               b_d      = issue_b;
               rd_d     = issue_rd;
               is_div_d = issue_is_div;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            wd_clear = 1'b1;
            if (flush) begin
               drain_new_d = 1'b1;
               state_d     = ST_DRAIN;
            end else begin
               state_d = ST_BLANK;
            end
         end
         ST_BLANK: begin
            if (flush) begin
               wd_clear    = 1'b1;
               drain_new_d = 1'b1;
               state_d     = ST_DRAIN;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            wd_enable = 1'b1;
            if (flush) begin
               // A result arriving with the flush leaves nothing in flight to drain.
               if (md_resultRDY) begin
                  state_d = ST_IDLE;
               end else begin
                  wd_clear    = 1'b1;
                  drain_new_d = 1'b1;
                  state_d     = ST_DRAIN;
               end
            end else if (md_resultRDY && !md_exception) begin
               wb_rd_d   = rd_q;
               wb_data_d = md_result;
               wb_exc_d  = 1'b0;
               state_d   = ST_WB;
            end else if (md_resultRDY || wd_tc) begin
               wb_rd_d   = EXC_REG;
               wb_data_d = is_div_q ? EXC_CODE_DIV : EXC_CODE_MUL;
               wb_exc_d  = 1'b1;
               state_d   = ST_WB;
            end
         end
         ST_WB: begin
            if (wb_ready) begin
               state_d = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            wd_enable = 1'b1;
            // Ready in the entry cycle may be multdiv's stale registered flag.
            if ((md_resultRDY && !drain_new_q) || wd_tc) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         rd_q        <= '0;
         is_div_q    <= 1'b0;
         drain_new_q <= 1'b0;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
         wb_exc_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         rd_q        <= rd_d;
         is_div_q    <= is_div_d;
         drain_new_q <= drain_new_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
         wb_exc_q    <= wb_exc_d;
      end
   end

   assign issue_ready  = (state_q == ST_IDLE);
   assign md_ctrl_MULT = (state_q == ST_START) && !is_div_q;
   assign md_ctrl_DIV  = (state_q == ST_START) && is_div_q;
   assign md_operandA  = a_q;
   assign md_operandB  = b_q;
   assign wb_valid     = (state_q == ST_WB);
   assign wb_rd        = wb_rd_q;
   assign wb_data      = wb_data_q;
   assign wb_exception = wb_exc_q;
   assign hazard_stall = is_busy(state_q) && (rd_q != REG_ZERO) &&
                         ((src1_rd == rd_q) || (src2_rd == rd_q));

endmodule
